// File: rtl/stall_scoreboard_pkg.sv
// Shared pipeline timing constants for the hazard scoreboard: Tuse/Tnew encodings
// and the default XALU occupancy lengths.
package stall_scoreboard_pkg;
  localparam int TUSE_D = 0;
  localparam int TUSE_E = 1;
  localparam int TUSE_M = 2;

  localparam int TNEW_LINK = 0;
  localparam int TNEW_ALU  = 1;
  localparam int TNEW_LOAD = 2;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/stall_scoreboard_if.sv
// D-stage hazard query bundle: source/destination descriptors in, stall/busy back.
interface stall_scoreboard_if #(
  parameter int NREG = 32,
  parameter int TW   = 2
);
  localparam int RW = $clog2(NREG);

  logic [RW-1:0] rs_d, rt_d, dst_d;
  logic          rs_use, rt_use, wr_d;
  logic [TW-1:0] tuse_rs, tuse_rt, tnew_d;
  logic          xalu_start_d, xalu_div_d, xalu_use_d;
  logic          flush;
  logic          stall, xalu_busy;

  modport master (
    output rs_d, rt_d, dst_d, rs_use, rt_use, wr_d, tuse_rs, tuse_rt, tnew_d,
           xalu_start_d, xalu_div_d, xalu_use_d, flush,
    input  stall, xalu_busy
  );
  modport slave (
    input  rs_d, rt_d, dst_d, rs_use, rt_use, wr_d, tuse_rs, tuse_rt, tnew_d,
           xalu_start_d, xalu_div_d, xalu_use_d, flush,
    output stall, xalu_busy
  );
endinterface

// File: rtl/stall_scoreboard_xalu_busy_ctr.sv
// Countdown of remaining mult/div occupancy; busy while nonzero.
module xalu_busy_ctr
  import stall_scoreboard_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);
  localparam int CW = $clog2(max2(MULT_CYC, DIV_CYC) + 1);

  logic [CW-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (start_i)              ctr_d = div_i ? CW'(DIV_CYC) : CW'(MULT_CYC);
    else if (ctr_q != '0)     ctr_d = ctr_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ctr_q <= '0;
    else        ctr_q <= ctr_d;
  end

  assign busy_o = (ctr_q != '0);
endmodule

// File: rtl/stall_scoreboard.sv
// Tnew/Tuse hazard scoreboard: per-register countdown of cycles until a result is
// forwardable, plus XALU occupancy, producing the F/D freeze signal.
module stall_scoreboard
  import stall_scoreboard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int TW       = 2,
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  stall_scoreboard_if.slave d
);
  localparam int RW = $clog2(NREG);

  logic [NREG-1:0][TW-1:0] cnt_q, cnt_d;
  logic haz_rs, haz_rt, haz_x, stall, xalu_busy, ld_en;

  assign haz_rs = d.rs_use && (d.rs_d != '0) && (cnt_q[d.rs_d] > d.tuse_rs);
  assign haz_rt = d.rt_use && (d.rt_d != '0) && (cnt_q[d.rt_d] > d.tuse_rt);
  assign haz_x  = xalu_busy && d.xalu_use_d;
  assign stall  = haz_rs || haz_rt || haz_x;
  assign ld_en  = !stall && d.wr_d && (d.dst_d != '0);

  // Load beats decrement on the same entry; flush beats both. Entry 0 is pinned at 0.
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < NREG; r++) begin
      if (r == 0 || d.flush)                    cnt_d[r] = '0;
      else if (ld_en && d.dst_d == RW'(r))      cnt_d[r] = d.tnew_d;
      else if (cnt_q[r] != '0)                  cnt_d[r] = cnt_q[r] - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  xalu_busy_ctr #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_xalu (
    .clk     (clk),
    .reset   (reset),
    .start_i (d.xalu_start_d && !stall),
    .div_i   (d.xalu_div_d),
    .busy_o  (xalu_busy)
  );

  assign d.stall     = stall;
  assign d.xalu_busy = xalu_busy;
endmodule

// File: doc/stall_scoreboard.md
STALL_SCOREBOARD -- requirements
Module: stall_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers tracked; register 0 never tracked.
REQ-002 SHALL have parameter TW, default 2, width of the Tnew/Tuse counters (max value 2**TW-1).
REQ-003 SHALL have parameter MULT_CYC, default 5, and DIV_CYC, default 10, as XALU busy lengths in cycles.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports rs_d and rt_d, input, log2(NREG) each, source register numbers of the D-stage instruction.
REQ-007 SHALL have ports rs_use and rt_use, input, 1 each, set when the D instruction reads that source.
REQ-008 SHALL have ports tuse_rs and tuse_rt, input, TW each, stages until each operand is consumed (0=D, 1=E, 2=M).
REQ-009 SHALL have port dst_d, input, log2(NREG), the D instruction's destination register.
REQ-010 SHALL have port wr_d, input, 1, set when the D instruction writes dst_d.
REQ-011 SHALL have port tnew_d, input, TW, cycles after entering E until the result is forwardable.
REQ-012 SHALL have ports xalu_start_d, input, 1, xalu_div_d, input, 1, and xalu_use_d, input, 1, marking mult/div start, divide select, and any XALU access (incl. mfhi/mflo/mthi/mtlo).
REQ-013 SHALL have port flush, input, 1, synchronous clear of all register countdowns.
REQ-014 SHALL have ports stall, output, 1, freeze F/D and bubble E; and xalu_busy, output, 1, XALU occupied.

Function
REQ-015 SHALL keep one TW-bit countdown cnt[r] per register r in 1..NREG-1.
REQ-016 SHALL assert stall combinationally when (rs_use and rs_d!=0 and cnt[rs_d]>tuse_rs) or the same for rt, or (xalu_busy and xalu_use_d).
REQ-017 SHALL, at each edge with stall low, wr_d high and dst_d!=0, load cnt[dst_d]<=tnew_d.
REQ-018 SHALL decrement every other nonzero cnt by 1 per cycle; saturate at 0.
REQ-019 SHALL give the load in REQ-017 priority over the decrement of the same entry (write-after-write overwrites).
REQ-020 SHALL not load any counter or start the XALU while stall is high; decrements continue during stall.
REQ-021 SHALL, with flush high, clear all cnt to 0 at the edge and ignore any simultaneous load; XALU busy counter unaffected.
REQ-022 SHALL keep an XALU busy counter, loaded with DIV_CYC if xalu_div_d else MULT_CYC when xalu_start_d and stall low, decremented while nonzero; xalu_busy = (counter!=0).
REQ-023 SHALL assert xalu_busy from the edge after the start for exactly MULT_CYC or DIV_CYC cycles.
REQ-024 SHALL treat an instruction with rs_use=rt_use=0 and xalu_use_d=0 (e.g. j) as never stalled.

Reset
REQ-025 SHALL, while reset is low, clear all cnt and the XALU counter asynchronously; stall=0, xalu_busy=0.
REQ-026 SHALL, on reset asserted mid-operation, discard all pending countdowns and any in-progress XALU busy period.

Structure
REQ-027 SHALL place Tuse/Tnew encodings (TUSE_D=0, TUSE_E=1, TUSE_M=2; TNEW_ALU=1, TNEW_LOAD=2, TNEW_LINK=0) and MULT_CYC/DIV_CYC defaults in a shared pipeline constants package.
REQ-028 SHALL contain one sub-module, xalu_busy_ctr, holding the XALU countdown; the scoreboard array stays in the top module.

Verification
REQ-029 SHALL cover: lw $8 (tnew 2) issued, next cycle add rs=$8 tuse 1 -> stall=1 for 1 cycle, 0 the following cycle.
REQ-030 SHALL cover: lw $8, next cycle beq rs=$8 tuse 0 -> stall=1 for 2 cycles, then 0.
REQ-031 SHALL cover: add $0 writes, next instruction reads $0 tuse 0 -> stall stays 0.
REQ-032 SHALL cover: div start, then mflo (xalu_use_d) next cycle -> stall=1 and xalu_busy=1 for DIV_CYC=10 cycles, stall 0 on cycle 11.
REQ-033 SHALL cover: lw $8 then flush next edge -> cnt[8]=0, dependent beq not stalled; reset low during div -> xalu_busy=0 immediately.
REQ-034 SHALL cover: back-to-back writes lw $9 (tnew 2) then add $9 (tnew 1) -> cnt[9]=1 after the second issue, consumer with tuse 0 stalls exactly 1 cycle.
